rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: WB0 (ALU result) and WB1 (load return).
- Uses round-robin arbitration with a valid/ready handshake and registers the RF write-port drive.
- Keeps a per-register pending-write scoreboard so the decode stage can detect RAW hazards against writes that are still in flight.
- Sits between the execute/memory stages and the register file's RFWE/RFWA/RFWD inputs.

---
 rtl/rf_wb_arbiter_if.sv | 37 +++
 rtl/rf_wb_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback/scoreboard bus between the execute/memory stages and the RF write-port arbiter.
// The slave side is the arbiter. The master side is the pipeline that drives it.
interface rf_wb_arbiter_if #(
    parameter int AWL = 6,
    parameter int DWL = 32
);
    logic           WB0_VALID;
    logic [AWL-2:0] WB0_ADDR;
    logic [DWL-1:0] WB0_DATA;
    logic           WB0_READY;
    logic           WB1_VALID;
    logic [AWL-2:0] WB1_ADDR;
    logic [DWL-1:0] WB1_DATA;
    logic           WB1_READY;
    logic           ALLOC_EN;
    logic [AWL-2:0] ALLOC_ADDR;
    logic [AWL-2:0] RA1;
    logic [AWL-2:0] RA2;
    logic           HAZ1;
    logic           HAZ2;
    logic           RFWE;
    logic [AWL-2:0] RFWA;
    logic [DWL-1:0] RFWD;
    logic           ERR;

    modport slave (
        input  WB0_VALID, WB0_ADDR, WB0_DATA, WB1_VALID, WB1_ADDR, WB1_DATA,
        input  ALLOC_EN, ALLOC_ADDR, RA1, RA2,
        output WB0_READY, WB1_READY, HAZ1, HAZ2, RFWE, RFWA, RFWD, ERR
    );

    modport master (
        output WB0_VALID, WB0_ADDR, WB0_DATA, WB1_VALID, WB1_ADDR, WB1_DATA,
        output ALLOC_EN, ALLOC_ADDR, RA1, RA2,
        input  WB0_READY, WB1_READY, HAZ1, HAZ2, RFWE, RFWA, RFWD, ERR
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single RF write port. It has a registered write drive and
// a per-register pending-write scoreboard that the decode stage uses for RAW hazard detection.
module rf_wb_arbiter #(
    parameter int AWL  = 6,
    parameter int DWL  = 32,
    parameter int NREG = 2**(AWL-1)
) (
    input  logic CLK,
    input  logic RST,
    rf_wb_arbiter_if.slave bus
);
    localparam int AW = AWL - 1;

    // ptr_reg = 0 favours WB0, ptr_reg = 1 favours WB1.
    logic           ptr_reg;
    logic           grant0;
    logic           grant1;
    logic           rfwe_reg;
    logic [AW-1:0]  rfwa_reg;
    logic [DWL-1:0] rfwd_reg;
    logic           err_reg;

    logic [NREG-1:0][1:0] cnt_reg;
    logic [NREG-1:0][1:0] cnt_next;
    logic [NREG-1:0]      bad_vec;

    // Grants depend only on the VALID inputs and the pointer. They never depend on ADDR or DATA.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!RST) begin
            grant0 = bus.WB0_VALID && (!bus.WB1_VALID || !ptr_reg);
            grant1 = bus.WB1_VALID && (!bus.WB0_VALID ||  ptr_reg);
        end
    end

    assign bus.WB0_READY = grant0;
    assign bus.WB1_READY = grant1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_reg  <= 1'b0;
            rfwe_reg <= 1'b0;
            rfwa_reg <= '0;
            rfwd_reg <= '0;
        end else begin
            rfwe_reg <= grant0 || grant1;
            if (grant0) begin
                ptr_reg  <= 1'b1;
                rfwa_reg <= bus.WB0_ADDR;
                rfwd_reg <= bus.WB0_DATA;
            end else if (grant1) begin
                ptr_reg  <= 1'b0;
                rfwa_reg <= bus.WB1_ADDR;
                rfwd_reg <= bus.WB1_DATA;
            end
        end
    end

    assign bus.RFWE = rfwe_reg;
    assign bus.RFWA = rfwa_reg;
    assign bus.RFWD = rfwd_reg;

    // Per-register saturating counter. An alloc and a commit at the same edge cancel out.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            logic       inc;
            logic       dec;
            logic [1:0] cnt_nx;
            logic       bad;

            assign inc = bus.ALLOC_EN && (bus.ALLOC_ADDR == AW'(gi));
            assign dec = rfwe_reg && (rfwa_reg == AW'(gi));

            always_comb begin
                cnt_nx = cnt_reg[gi];
                bad    = 1'b0;
                if (inc && !dec) begin
                    if (cnt_reg[gi] == 2'd3) bad = 1'b1;
                    else                     cnt_nx = cnt_reg[gi] + 2'd1;
                end else if (dec && !inc) begin
                    if (cnt_reg[gi] == 2'd0) bad = 1'b1;
                    else                     cnt_nx = cnt_reg[gi] - 2'd1;
                end
            end

            assign cnt_next[gi] = cnt_nx;
            assign bad_vec[gi]  = bad;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_reg || (|bad_vec);
        end
    end

    assign bus.ERR = err_reg;

    // HAZ reads the pre-commit count, so it stays high through the commit cycle.
    assign bus.HAZ1 = (cnt_reg[bus.RA1] != 2'd0);
    assign bus.HAZ2 = (cnt_reg[bus.RA2] != 2'd0);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter. Each table row is one clock cycle of
// inputs plus the outputs expected in that same cycle.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.AWL(6), .DWL(32)) bus();

    rf_wb_arbiter #(.AWL(6), .DWL(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        al;
        logic [4:0]  ala;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        h1;
        logic        h2;
        logic        er;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t v(
        input bit rst_i, input bit v0, input int a0, input logic [31:0] d0,
        input bit v1, input int a1, input logic [31:0] d1,
        input bit al, input int ala, input int ra1, input int ra2,
        input bit r0, input bit r1, input bit we, input int wa, input logic [31:0] wd,
        input bit h1, input bit h2, input bit er);
        vec_t x;
        x.rst = rst_i; x.v0 = v0; x.a0 = 5'(a0); x.d0 = d0;
        x.v1 = v1; x.a1 = 5'(a1); x.d1 = d1;
        x.al = al; x.ala = 5'(ala); x.ra1 = 5'(ra1); x.ra2 = 5'(ra2);
        x.r0 = r0; x.r1 = r1; x.we = we; x.wa = 5'(wa); x.wd = wd;
        x.h1 = h1; x.h2 = h2; x.er = er;
        return x;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        rst            = x.rst;
        bus.WB0_VALID  = x.v0;  bus.WB0_ADDR = x.a0;  bus.WB0_DATA = x.d0;
        bus.WB1_VALID  = x.v1;  bus.WB1_ADDR = x.a1;  bus.WB1_DATA = x.d1;
        bus.ALLOC_EN   = x.al;  bus.ALLOC_ADDR = x.ala;
        bus.RA1        = x.ra1; bus.RA2 = x.ra2;
    endtask

    initial begin
        //          rst v0 a0 d0            v1 a1 d1      al ala ra1 ra2 | r0 r1 we wa wd            h1 h2 er
        tv.push_back(v(1, 1,1,'hA0,         1,2,'hB0,     0,0,  0,0,   0,0, 0,0,0,             0,0,0)); // 0 reset, both valid
        tv.push_back(v(0, 1,1,'hA0,         1,2,'hB0,     0,0,  0,0,   1,0, 0,0,0,             0,0,0)); // 1 WB0 first
        tv.push_back(v(0, 1,1,'hA1,         1,2,'hB0,     0,0,  0,0,   0,1, 1,1,'hA0,          0,0,0));
        tv.push_back(v(0, 1,1,'hA1,         1,2,'hB1,     0,0,  0,0,   1,0, 1,2,'hB0,          0,0,1)); // unallocated commit
        tv.push_back(v(0, 1,1,'hA2,         1,2,'hB1,     0,0,  0,0,   0,1, 1,1,'hA1,          0,0,1));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  0,0,   0,0, 1,2,'hB1,          0,0,1));
        tv.push_back(v(0, 1,5,32'hDEADBEEF, 0,0,0,        0,0,  0,0,   1,0, 0,2,'hB1,          0,0,1));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  0,0,   0,0, 1,5,32'hDEADBEEF,  0,0,1));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  0,0,   0,0, 0,5,32'hDEADBEEF,  0,0,1));
        tv.push_back(v(0, 1,6,'h66,         0,0,0,        0,0,  0,0,   1,0, 0,5,32'hDEADBEEF,  0,0,1)); // lone WB0 vs ptr=1
        tv.push_back(v(0, 0,0,0,            1,8,'h88,     0,0,  0,0,   0,1, 1,6,'h66,          0,0,1));
        tv.push_back(v(1, 1,1,'hA0,         1,2,'hB0,     0,0,  0,0,   0,0, 1,8,'h88,          0,0,1)); // 11 reset w/ pending
        tv.push_back(v(0, 1,1,'hA0,         1,2,'hB0,     1,1,  1,0,   1,0, 0,0,0,             0,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  1,0,   0,0, 1,1,'hA0,          1,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  1,0,   0,0, 0,1,'hA0,          0,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        1,7,  7,0,   0,0, 0,1,'hA0,          0,0,0)); // 15 alloc 7
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  7,0,   0,0, 0,1,'hA0,          1,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  7,0,   0,0, 0,1,'hA0,          1,0,0));
        tv.push_back(v(0, 0,0,0,            1,7,'h77,     0,0,  7,0,   0,1, 0,1,'hA0,          1,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  7,0,   0,0, 1,7,'h77,          1,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  7,0,   0,0, 0,7,'h77,          0,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        1,9,  0,9,   0,0, 0,7,'h77,          0,0,0)); // 21 alloc 9 x4
        tv.push_back(v(0, 0,0,0,            0,0,0,        1,9,  0,9,   0,0, 0,7,'h77,          0,1,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        1,9,  0,9,   0,0, 0,7,'h77,          0,1,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        1,9,  0,9,   0,0, 0,7,'h77,          0,1,0));
        tv.push_back(v(0, 1,9,'h91,         0,0,0,        0,0,  0,9,   1,0, 0,7,'h77,          0,1,1));
        tv.push_back(v(0, 1,9,'h92,         0,0,0,        0,0,  0,9,   1,0, 1,9,'h91,          0,1,1));
        tv.push_back(v(0, 0,0,0,            1,9,'h93,     0,0,  0,9,   0,1, 1,9,'h92,          0,1,1));
        tv.push_back(v(0, 1,9,'h94,         0,0,0,        0,0,  0,9,   1,0, 1,9,'h93,          0,1,1));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  0,9,   0,0, 1,9,'h94,          0,0,1));
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  0,9,   0,0, 0,9,'h94,          0,0,1));
        tv.push_back(v(1, 0,0,0,            0,0,0,        0,0,  0,9,   0,0, 0,9,'h94,          0,0,1)); // 31 clear ERR
        tv.push_back(v(0, 1,3,'h33,         0,0,0,        1,3,  3,0,   1,0, 0,0,0,             0,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        1,3,  3,0,   0,0, 1,3,'h33,          1,0,0)); // alloc+commit 3
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  3,0,   0,0, 0,3,'h33,          1,0,0));
        tv.push_back(v(0, 0,0,0,            1,3,'h34,     0,0,  3,0,   0,1, 0,3,'h33,          1,0,0));
        tv.push_back(v(0, 0,0,0,            0,0,0,        1,4,  3,4,   0,0, 1,3,'h34,          1,0,0)); // commit 3, alloc 4
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  3,4,   0,0, 0,3,'h34,          0,1,0));
        tv.push_back(v(0, 1,4,'h44,         0,0,0,        0,0,  3,4,   1,0, 0,3,'h34,          0,1,0));
        tv.push_back(v(1, 0,0,0,            0,0,0,        0,0,  3,4,   0,0, 1,4,'h44,          0,1,0)); // reset drops commit
        tv.push_back(v(0, 0,0,0,            0,0,0,        0,0,  3,4,   0,0, 0,0,0,             0,0,0));

        apply(v(1, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            #1;
            apply(tv[i]);
            @(negedge clk);
            check("WB0_READY", i, 32'(bus.WB0_READY), 32'(tv[i].r0));
            check("WB1_READY", i, 32'(bus.WB1_READY), 32'(tv[i].r1));
            check("RFWE",      i, 32'(bus.RFWE),      32'(tv[i].we));
            check("RFWA",      i, 32'(bus.RFWA),      32'(tv[i].wa));
            check("RFWD",      i, bus.RFWD,           tv[i].wd);
            check("HAZ1",      i, 32'(bus.HAZ1),      32'(tv[i].h1));
            check("HAZ2",      i, 32'(bus.HAZ2),      32'(tv[i].h2));
            check("ERR",       i, 32'(bus.ERR),       32'(tv[i].er));
            $display("row %2d: rdy=%b%b rfwe=%b rfwa=%0d rfwd=%h haz=%b%b err=%b", i,
                     bus.WB0_READY, bus.WB1_READY, bus.RFWE, bus.RFWA, bus.RFWD,
                     bus.HAZ1, bus.HAZ2, bus.ERR);
            @(posedge clk);
        end

        // Within one cycle: READY must not follow ADDR/DATA, and a dropped VALID is never granted.
        #1;
        bus.WB0_VALID = 1'b1;
        bus.WB1_VALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.WB0_ADDR = 5'($urandom_range(31, 0));
            bus.WB0_DATA = $urandom;
            #1;
            check("READY_vs_payload", 100 + k, {30'd0, bus.WB0_READY, bus.WB1_READY}, 32'd2);
        end
        bus.WB0_VALID = 1'b0;
        #1;
        check("dropped_valid", 104, {30'd0, bus.WB0_READY, bus.WB1_READY}, 32'd0);
        bus.WB0_VALID = 1'b1;
        bus.WB1_VALID = 1'b1;
        #1;
        check("both_ptr0", 105, {30'd0, bus.WB0_READY, bus.WB1_READY}, 32'd2);
        bus.WB0_VALID = 1'b0;
        bus.WB1_VALID = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
